// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants and types for the PS/2 scan-code-set-2 keyboard front end.
package ps2_key_decoder_pkg;

  localparam int unsigned KEY_CODE_W = 9;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam logic [7:0] PS2_IGN_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_IGN_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_IGN_ACK    = 8'hFA;
  localparam logic [7:0] PS2_IGN_RESEND = 8'hFE;
  localparam logic [7:0] PS2_IGN_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_IGN_ERR0   = 8'h00;
  localparam logic [7:0] PS2_IGN_ERR1   = 8'hFF;
  localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;
  typedef enum logic [1:0] {StDIdle, StDE0, StDF0, StDE0F0} dec_state_e;

  // Bytes that carry no key information outside an extended/break sequence.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == PS2_IGN_PAUSE)  || (b == PS2_IGN_BAT_OK) || (b == PS2_IGN_ACK) ||
           (b == PS2_IGN_RESEND) || (b == PS2_IGN_ECHO)   || (b == PS2_IGN_ERR0) ||
           (b == PS2_IGN_ERR1);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 device-to-host receiver: synchronise, debounce clock, frame 11-bit words, timeout.
module ps2_rx
  import ps2_key_decoder_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          strobe_q, strobe_d;

  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          sdata;

  assign sdata = data_sync_q[1];

  // Filtered clock follows the synchronised line only after FILTER_LEN differing samples.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    strobe_d   = 1'b0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d   = clk_sync_q[1];
        strobe_d = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    tmo_d        = (state_q == StIdle || strobe_q) ? '0 : tmo_q + 1'b1;

    if (state_q != StIdle && !strobe_q && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      frame_err_d = 1'b1;
      state_d     = StIdle;
      tmo_d       = '0;
    end else if (strobe_q) begin
      unique case (state_q)
        StIdle: begin
          if (!sdata) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          shift_d   = {sdata, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          parity_d = sdata;
          state_d  = StStop;
        end
        StStop: begin
          if (sdata && (^{shift_q, parity_q})) byte_valid_d = 1'b1;
          else                                 frame_err_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q   <= 2'b11;
      data_sync_q  <= 2'b11;
      filt_q       <= 1'b1;
      filt_cnt_q   <= '0;
      strobe_q     <= 1'b0;
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tmo_q        <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], ps2_clk};
      data_sync_q  <= {data_sync_q[0], ps2_data};
      filt_q       <= filt_d;
      filt_cnt_q   <= filt_cnt_d;
      strobe_q     <= strobe_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tmo_q        <= tmo_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_byte    = shift_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Scan-code-set-2 make/break decoder maintaining a 512-bit pressed-key bitmap.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  output logic [511:0]          key_down,
  output logic [KEY_CODE_W-1:0] last_change,
  output logic                  key_valid,
  output logic                  frame_err
);

  logic [7:0] rx_byte;
  logic       byte_valid;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  dec_state_e            dec_q, dec_d;
  logic                  ev_valid, ev_make;
  logic [KEY_CODE_W-1:0] ev_code;
  logic [511:0]          key_down_q;
  logic [KEY_CODE_W-1:0] last_change_q;
  logic                  key_valid_q;

  always_comb begin
    dec_d    = dec_q;
    ev_valid = 1'b0;
    ev_make  = 1'b0;
    ev_code  = '0;
    if (byte_valid) begin
      unique case (dec_q)
        StDIdle: begin
          if (rx_byte == PS2_PREFIX_EXT)      dec_d = StDE0;
          else if (rx_byte == PS2_PREFIX_BRK) dec_d = StDF0;
          else if (!is_ignored(rx_byte)) begin
            ev_valid = 1'b1;
            ev_make  = 1'b1;
            ev_code  = {1'b0, rx_byte};
          end
        end
        StDE0: begin
          dec_d = StDIdle;
          if (rx_byte == PS2_PREFIX_BRK) dec_d = StDE0F0;
          else if (rx_byte != PS2_FAKE_SHIFT) begin
            ev_valid = 1'b1;
            ev_make  = 1'b1;
            ev_code  = {1'b1, rx_byte};
          end
        end
        StDF0, StDE0F0: begin
          dec_d = StDIdle;
          // A stray prefix inside a break sequence means we lost sync; drop it.
          if (rx_byte != PS2_PREFIX_EXT && rx_byte != PS2_PREFIX_BRK) begin
            ev_valid = 1'b1;
            ev_code  = {(dec_q == StDE0F0), rx_byte};
          end
        end
        default: dec_d = StDIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q         <= StDIdle;
      key_down_q    <= '0;
      last_change_q <= '0;
      key_valid_q   <= 1'b0;
    end else begin
      dec_q       <= dec_d;
      key_valid_q <= ev_valid;
      if (ev_valid) begin
        key_down_q[ev_code] <= ev_make;
        last_change_q       <= ev_code;
      end
    end
  end

  assign key_down    = key_down_q;
  assign last_change = last_change_q;
  assign key_valid   = key_valid_q;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Front-end keyboard stage. It receives raw PS/2 device-to-host frames on ps2_clk/ps2_data and decodes scan-code-set-2 make/break sequences, including the E0 extended and F0 break prefixes. It maintains a 512-bit pressed-key bitmap and emits a one-cycle key event. Its outputs key_down, last_change and key_valid feed the game-control stage (direction decoder) directly.

Parameters:
FILTER_LEN, 8, consecutive identical samples required before filtered ps2_clk changes level (debounce)
TIMEOUT_CYCLES, 20000, clk cycles with no ps2_clk falling edge mid-frame before the frame is aborted (200 us at 100 MHz)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
ps2_clk  in  1  raw PS/2 clock from connector, asynchronous
ps2_data  in  1  raw PS/2 data from connector, asynchronous
key_down  out  512  bit n = 1 while key with code n is held; n = {ext, byte[7:0]}
last_change  out  9  code of most recent make or break event, {ext, byte}
key_valid  out  1  one-cycle pulse: last_change/key_down updated this cycle
frame_err  out  1  one-cycle pulse: received frame discarded (start/parity/stop/timeout)

Behaviour:
- Reset values: key_down = 0, last_change = 9'h000, key_valid = 0, frame_err = 0; receiver in IDLE; decoder in D_IDLE. Reset mid-frame discards partial bits.
- Input conditioning: 2-FF synchronisers on ps2_clk and ps2_data. Filtered clock toggles only after FILTER_LEN equal samples. Falling edge of the filtered clock = one-cycle sample strobe. Data is sampled from the synchronised ps2_data at the strobe.
- Receiver FSM (11-bit frame, LSB first):
  - IDLE: on strobe with data=0 -> DATA with bit count 0. On strobe with data=1 -> stay, no error.
  - DATA: 8 strobes shift bits into byte[0..7] -> PARITY.
  - PARITY: capture the bit -> STOP.
  - STOP: on strobe, the frame is good if the stop bit = 1 and ^{byte, parity} = 1 (odd parity). Good frame -> byte_valid pulse for 1 cycle. Bad frame -> frame_err pulse. Either way -> IDLE.
  - Timeout counter resets on every strobe and counts in any state except IDLE. Reaching TIMEOUT_CYCLES-1 -> frame_err pulse, go to IDLE.
- Decoder FSM, advanced on each byte_valid:
  - D_IDLE: E0 -> D_E0. F0 -> D_F0. E1, AA, FA, FE, EE, 00, FF -> ignored, stay in D_IDLE. Any other byte b -> make event, code {0,b}.
  - D_E0: F0 -> D_E0F0. Byte 12 (fake shift) -> ignored, return to D_IDLE. Other b -> make, code {1,b}.
  - D_F0: b -> break, code {0,b}. D_E0F0: b -> break, code {1,b}. A prefix byte (E0/F0) arriving in either break state -> discard, return to D_IDLE.
  - After any event or discard -> D_IDLE.
- Event timing: on the clk edge following the byte_valid cycle, key_valid=1, last_change=code and key_down[code] are written together on the same edge (make: set bit, break: clear bit). A consumer sampling key_down[last_change] when key_valid=1 therefore sees the new value.
- Repeated make (typematic) produces key_valid on every repeat; the bit stays 1. A break for a key not held still pulses key_valid; the bit stays 0.
- Pause key (E1 sequence) is not supported; its trailing bytes decode as ordinary codes.
- key_valid and frame_err are never asserted in the same cycle (one byte per frame, errors produce no byte).

Decomposition:
- Shared package: PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0, ignored-byte constants (E1, AA, FA, FE, EE, 00, FF, fake shift 12), and the 9-bit key code width.
- Sub-module ps2_rx: synchronise, filter, frame receive, timeout. Outputs byte[7:0], byte_valid and frame_err. The top module holds the decoder FSM and the key_down register.

Test Plan:
- Frame 1D (W, odd parity) -> one key_valid, last_change=9'h01D, key_down[29]=1, all other bits 0.
- Then F0,1D -> exactly one key_valid after the 1D frame, last_change=9'h01D, key_down[29]=0; no pulse for F0.
- E0,75 then E0,F0,75 (up arrow) -> make: last_change=9'h175, key_down[373]=1; break: key_down[373]=0.
- Frame 1C with wrong parity -> frame_err pulse, no key_valid, key_down unchanged; next good frame 1C -> decoded normally.
- Stop ps2_clk after 4 data bits for >TIMEOUT_CYCLES -> frame_err; following full frame 23 -> last_change=9'h023, key_down[35]=1.
- Assert rst mid-frame with keys 1D and 1B held -> key_down=0, last_change=0; next clean frame 1B -> key_down[27]=1 only. Also apply glitch pulses shorter than FILTER_LEN on ps2_clk during the frame -> no extra bits received.
